// File: rtl/conv_line_buffer.sv
// Line buffer that turns a raster pixel stream into three row-aligned streams
// (rows r-2, r-1, r) for a downstream 3x3 convolution stage.
//
// Ports:
//   i_clk, i_rst_n              clock, async active-low reset
//   i_start                     begin a new frame (sampled in IDLE only)
//   i_pix_data/i_pix_valid      raster-order input pixel
//   o_pix_ready                 input pixel accepted when valid & ready
//   o_row1/2/3_data, o_col      one column of rows r-2, r-1, r
//   o_valid/i_ready             output beat handshake
//   o_frame_done                1-cycle pulse after the last beat
module conv_line_buffer #(
  parameter int BIT_DEPTH  = 8,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_start,
  input  logic [BIT_DEPTH-1:0]         i_pix_data,
  input  logic                         i_pix_valid,
  output logic                         o_pix_ready,
  output logic [BIT_DEPTH-1:0]         o_row1_data,
  output logic [BIT_DEPTH-1:0]         o_row2_data,
  output logic [BIT_DEPTH-1:0]         o_row3_data,
  output logic [$clog2(IMG_WIDTH)-1:0] o_col,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic                         o_frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    STREAM,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          last_taken;
  logic          col_last;
  logic          row_last;
  logic          accept;
  logic          out_free;
  logic          new_frame;

  // lineA holds row r-2, lineB holds row r-1
  logic [BIT_DEPTH-1:0] line_a [IMG_WIDTH];
  logic [BIT_DEPTH-1:0] line_b [IMG_WIDTH];
  logic [BIT_DEPTH-1:0] rd_a;
  logic [BIT_DEPTH-1:0] rd_b;

  assign col_last  = (col == CW'(IMG_WIDTH - 1));
  assign row_last  = (row == RW'(IMG_HEIGHT - 1));
  assign out_free  = ~o_valid | i_ready;
  assign new_frame = (state == IDLE) & i_start;

  // Once the final pixel is in, stop accepting until the frame drains.
  assign o_pix_ready = (state == FILL)
                     | ((state == STREAM) & out_free & ~last_taken);

  assign accept = i_pix_valid & o_pix_ready;

  // Combinational reads see the pre-edge contents: read-before-write.
  assign rd_a = line_a[col];
  assign rd_b = line_b[col];

  always_comb begin
    state_nxt    = state;
    o_frame_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_start) state_nxt = FILL;
      end
      FILL: begin
        if (accept & col_last & (row == RW'(1)))
          state_nxt = STREAM;
      end
      STREAM: begin
        if (last_taken & o_valid & i_ready)
          state_nxt = DONE;
      end
      DONE: begin
        o_frame_done = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col        <= '0;
      row        <= '0;
      last_taken <= 1'b0;
    end else if (new_frame) begin
      col        <= '0;
      row        <= '0;
      last_taken <= 1'b0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
      if ((state == STREAM) & col_last & row_last)
        last_taken <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      line_a[col] <= rd_b;
      line_b[col] <= i_pix_data;
    end
  end

  // A new beat may load in the same cycle the old one leaves; o_valid
  // only drops when the beat leaves with nothing behind it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_row1_data <= '0;
      o_row2_data <= '0;
      o_row3_data <= '0;
      o_col       <= '0;
      o_valid     <= 1'b0;
    end else if (accept & (state == STREAM)) begin
      o_row1_data <= rd_a;
      o_row2_data <= rd_b;
      o_row3_data <= i_pix_data;
      o_col       <= col;
      o_valid     <= 1'b1;
    end else if (o_valid & i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule
